pp_gen_8: RTL

//  Partial-product generator feeding carry_save_8 directly. Captures one operand pair and SEW via a valid/ready

---
 rtl/pp_gen_8.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pp_gen_8.sv
// rtl/pp_gen_8.sv - partial-product generator and sequencer for carry_save_8
//
// Captures one operand pair plus SEW, then drives eight registered unsigned
// 8x8 partial products to carry_save_8 together with its start pulse, the SEW
// code and a result-valid strobe. 32-bit operations take two passes.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_valid / in_ready operand handshake (in_ready = idle)
//   op_a, op_b          32-bit operands, byte 0 = [7:0]
//   sew                 00=4x8b, 01=2x16b, 10=1x32b, 11=illegal
//   res_ready           result accepted (only with PPGEN_HOLD_EN)
//   cs_start            one-cycle start pulse to carry_save_8
//   cs_sew              SEW captured at accept
//   mult_out_1..8       registered partial products
//   res_valid           carry_save_8 result valid this cycle
//   err_sew             one-cycle pulse after an illegal SEW offer
//
// Build option:
//   PPGEN_HOLD_EN       DONE holds res_valid until res_ready is high
module pp_gen_8 #(
    parameter int OP_W = 32,
    parameter int PP_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op_a,
    input  logic [OP_W-1:0] op_b,
    input  logic [1:0]      sew,
    input  logic            res_ready,
    output logic            cs_start,
    output logic [1:0]      cs_sew,
    output logic [PP_W-1:0] mult_out_1,
    output logic [PP_W-1:0] mult_out_2,
    output logic [PP_W-1:0] mult_out_3,
    output logic [PP_W-1:0] mult_out_4,
    output logic [PP_W-1:0] mult_out_5,
    output logic [PP_W-1:0] mult_out_6,
    output logic [PP_W-1:0] mult_out_7,
    output logic [PP_W-1:0] mult_out_8,
    output logic            res_valid,
    output logic            err_sew
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_PASS1,
        S_PASS2,
        S_DONE
    } state_t;

    localparam logic [1:0] SEW_8   = 2'b00;
    localparam logic [1:0] SEW_16  = 2'b01;
    localparam logic [1:0] SEW_32  = 2'b10;
    localparam logic [1:0] SEW_BAD = 2'b11;

    state_t                r_state;
    state_t                w_next;
    logic [OP_W-1:0]       r_a;
    logic [OP_W-1:0]       r_b;
    logic [1:0]            r_sew;
    logic                  r_err_sew;
    logic [7:0][PP_W-1:0]  r_m;
    logic [7:0][PP_W-1:0]  w_pp;
    logic                  w_accept;
    logic                  w_load;
    logic [7:0]            w_bl;
    logic [7:0]            w_bh;

    function automatic logic [PP_W-1:0] mul8(input logic [7:0] x, input logic [7:0] y);
        return {8'd0, x} * {8'd0, y};
    endfunction

    assign w_accept = (r_state == S_IDLE) && in_valid && (sew != SEW_BAD);
    // Pass 1 loads in ISSUE; only 32-bit needs a second load while in PASS1.
    assign w_load   = (r_state == S_ISSUE) || ((r_state == S_PASS1) && (r_sew == SEW_32));

    // In PASS1 the loaded products belong to pass 2, which uses the upper b bytes.
    assign w_bl = (r_state == S_PASS1) ? r_b[23:16] : r_b[7:0];
    assign w_bh = (r_state == S_PASS1) ? r_b[31:24] : r_b[15:8];

    always_comb begin
        w_pp = '0;
        case (r_sew)
            SEW_8: begin
                w_pp[0] = mul8(r_a[7:0],   r_b[7:0]);
                w_pp[1] = mul8(r_a[15:8],  r_b[15:8]);
                w_pp[2] = mul8(r_a[23:16], r_b[23:16]);
                w_pp[3] = mul8(r_a[31:24], r_b[31:24]);
            end
            SEW_16: begin
                w_pp[0] = mul8(r_a[7:0],   r_b[7:0]);
                w_pp[1] = mul8(r_a[15:8],  r_b[7:0]);
                w_pp[2] = mul8(r_a[7:0],   r_b[15:8]);
                w_pp[3] = mul8(r_a[15:8],  r_b[15:8]);
                w_pp[4] = mul8(r_a[23:16], r_b[23:16]);
                w_pp[5] = mul8(r_a[31:24], r_b[23:16]);
                w_pp[6] = mul8(r_a[23:16], r_b[31:24]);
                w_pp[7] = mul8(r_a[31:24], r_b[31:24]);
            end
            SEW_32: begin
                w_pp[0] = mul8(r_a[7:0],   w_bl);
                w_pp[1] = mul8(r_a[15:8],  w_bl);
                w_pp[2] = mul8(r_a[23:16], w_bl);
                w_pp[3] = mul8(r_a[31:24], w_bl);
                w_pp[4] = mul8(r_a[7:0],   w_bh);
                w_pp[5] = mul8(r_a[15:8],  w_bh);
                w_pp[6] = mul8(r_a[23:16], w_bh);
                w_pp[7] = mul8(r_a[31:24], w_bh);
            end
            default: w_pp = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

`ifdef PPGEN_HOLD_EN
    logic w_done_exit;
    assign w_done_exit = res_ready;
`else
    logic w_done_exit;
    logic w_unused_res_ready;
    assign w_done_exit        = 1'b1;
    assign w_unused_res_ready = res_ready;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ISSUE;
            S_ISSUE: w_next = S_PASS1;
            S_PASS1: w_next = (r_sew == SEW_32) ? S_PASS2 : S_DONE;
            S_PASS2: w_next = S_DONE;
            S_DONE:  if (w_done_exit) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_sew     <= '0;
            r_err_sew <= 1'b0;
            r_m       <= '0;
        end else begin
            r_err_sew <= (r_state == S_IDLE) && in_valid && (sew == SEW_BAD);
            if (w_accept) begin
                r_a   <= op_a;
                r_b   <= op_b;
                r_sew <= sew;
            end
            if (w_load) begin
                r_m <= w_pp;
            end
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign cs_start   = (r_state == S_ISSUE);
    assign res_valid  = (r_state == S_DONE);
    assign cs_sew     = r_sew;
    assign err_sew    = r_err_sew;
    assign mult_out_1 = r_m[0];
    assign mult_out_2 = r_m[1];
    assign mult_out_3 = r_m[2];
    assign mult_out_4 = r_m[3];
    assign mult_out_5 = r_m[4];
    assign mult_out_6 = r_m[5];
    assign mult_out_7 = r_m[6];
    assign mult_out_8 = r_m[7];

endmodule
